// File: rtl/cpu_pkg.sv
// Shared CPU constants: data width, ALU opcodes and ALU FSM state encoding.
// Used by alu_acc and alu_mul_seq; CPU_WIDTH must track the register-file width.
package cpu_pkg;

  localparam int CPU_WIDTH = 8;
  localparam int OP_W      = 4;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LD  = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_ADC = 3;
  localparam int unsigned OP_SUB = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_OR  = 6;
  localparam int unsigned OP_XOR = 7;
  localparam int unsigned OP_NOT = 8;
  localparam int unsigned OP_SHL = 9;
  localparam int unsigned OP_SHR = 10;
  localparam int unsigned OP_MUL = 11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one iteration per cycle, WIDTH iterations per product.
// o_last/o_prod are combinational so the owner can commit the product on the final edge.
module alu_mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_run,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  // Upper half gathers partial sums; the multiplier drains out of the lower half.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};

  assign o_last = i_run && (r_cnt == CW'(WIDTH - 1));
  assign o_prod = w_prod_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= i_mcand;
      r_prod  <= {{WIDTH{1'b0}}, i_mplier};
      r_cnt   <= '0;
    end else if (i_run) begin
      r_prod  <= w_prod_nxt;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_acc.sv
// Accumulator ALU feeding the register-file write bus, operand B from its read bus.
// Define ALU_MUL_EN to include the multi-cycle MUL opcode, HI register and BUSY handshake.
module alu_acc
  import cpu_pkg::*;
#(
  parameter int WIDTH   = CPU_WIDTH,
  parameter int OP_SIZE = OP_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [OP_SIZE-1:0] i_op,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_acc,
  output logic [WIDTH-1:0]   o_hi,
  output logic               o_c,
  output logic               o_z,
  output logic               o_busy,
  output logic               o_done
);

  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_z;
  logic             r_done;

  logic [31:0]      w_opcode;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sumc;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_c_nxt;
  logic             w_upd;
  logic             w_is_mul;
  logic             w_busy;
  logic             w_accept;
  logic             w_mul_last;

  assign w_opcode = 32'(i_op);
  assign w_accept = i_en && !w_busy;
  assign w_sum    = {1'b0, r_acc} + {1'b0, i_b};
  assign w_sumc   = w_sum + (WIDTH + 1)'(r_c);
  assign w_diff   = {1'b0, r_acc} - {1'b0, i_b};

  always_comb begin
    w_acc_nxt = r_acc;
    w_c_nxt   = r_c;
    w_upd     = 1'b1;
    w_is_mul  = 1'b0;
    case (w_opcode)
      OP_LD:  w_acc_nxt = i_b;
      OP_ADD: {w_c_nxt, w_acc_nxt} = w_sum;
      OP_ADC: {w_c_nxt, w_acc_nxt} = w_sumc;
      OP_SUB: {w_c_nxt, w_acc_nxt} = w_diff;
      OP_AND: w_acc_nxt = r_acc & i_b;
      OP_OR:  w_acc_nxt = r_acc | i_b;
      OP_XOR: w_acc_nxt = r_acc ^ i_b;
      OP_NOT: w_acc_nxt = ~r_acc;
      OP_SHL: begin
        w_c_nxt   = r_acc[WIDTH-1];
        w_acc_nxt = {r_acc[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        w_c_nxt   = r_acc[0];
        w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        w_upd    = 1'b0;
        w_is_mul = 1'b1;
      end
`endif
      default: w_upd = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_hi;
  logic [2*WIDTH-1:0] w_prod;

  assign w_busy = (r_state == ST_MUL);

  alu_mul_seq #(
    .WIDTH    (WIDTH)
  ) u_mul (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_accept && w_is_mul),
    .i_run    (w_busy),
    .i_mcand  (r_acc),
    .i_mplier (i_b),
    .o_last   (w_mul_last),
    .o_prod   (w_prod)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept && w_is_mul) r_state <= ST_MUL;
        ST_MUL:  if (w_mul_last) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi <= '0;
    end else if (w_mul_last) begin
      r_hi <= w_prod[2*WIDTH-1:WIDTH];
    end
  end

  assign o_hi = r_hi;
`else
  // Without the multiplier the FSM never leaves IDLE.
  assign w_busy     = 1'b0;
  assign w_mul_last = 1'b0;
  assign o_hi       = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_z    <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifdef ALU_MUL_EN
      if (w_mul_last) begin
        r_acc  <= w_prod[WIDTH-1:0];
        r_c    <= 1'b0;
        r_z    <= (w_prod == '0);
        r_done <= 1'b1;
      end else
`endif
      if (w_accept) begin
        // MUL acceptance defers DONE and all result updates to its final iteration.
        if (!w_is_mul) r_done <= 1'b1;
        if (w_upd) begin
          r_acc <= w_acc_nxt;
          r_c   <= w_c_nxt;
          r_z   <= (w_acc_nxt == '0);
        end
      end
    end
  end

  assign o_acc  = r_acc;
  assign o_c    = r_c;
  assign o_z    = r_z;
  assign o_busy = w_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_alu_acc.sv
// Directed self-checking bench for alu_acc; MUL scenarios run when ALU_MUL_EN is defined.
module tb_alu_acc;

  localparam logic [3:0] NOP = 4'd0,  LD  = 4'd1,  ADD = 4'd2,  ADC = 4'd3;
  localparam logic [3:0] SUB = 4'd4,  AND = 4'd5,  OR  = 4'd6,  XOR = 4'd7;
  localparam logic [3:0] NOT = 4'd8,  SHL = 4'd9,  SHR = 4'd10, MUL = 4'd11;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic [3:0] i_op;
  logic [7:0] i_b;
  logic [7:0] o_acc;
  logic [7:0] o_hi;
  logic       o_c;
  logic       o_z;
  logic       o_busy;
  logic       o_done;

  int checks = 0;
  int failures = 0;

  alu_acc #(
    .WIDTH   (8),
    .OP_SIZE (4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_op   (i_op),
    .i_b    (i_b),
    .o_acc  (o_acc),
    .o_hi   (o_hi),
    .o_c    (o_c),
    .o_z    (o_z),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Present one set of inputs at the falling edge, then sample 1ns past the next rising edge.
  task automatic applyStimulus(input logic en, input logic [3:0] op, input logic [7:0] b);
    @(negedge i_clk);
    i_en = en;
    i_op = op;
    i_b  = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    i_en  = 1'b0;
    i_op  = NOP;
    i_b   = 8'h00;
    #2;
    checkOutput("rst_acc", o_acc, 8'h00);
    checkOutput("rst_z",   o_z,   1);
    checkOutput("rst_c",   o_c,   0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Dirty the state, then pulse reset between clock edges.
    applyStimulus(1, LD, 8'hAA);
    checkOutput("ld_aa_acc", o_acc, 8'hAA);
    #3;
    i_rst = 1'b1;
    #1;
    checkOutput("async_rst_acc",  o_acc,  8'h00);
    checkOutput("async_rst_hi",   o_hi,   8'h00);
    checkOutput("async_rst_z",    o_z,    1);
    checkOutput("async_rst_c",    o_c,    0);
    checkOutput("async_rst_busy", o_busy, 0);
    checkOutput("async_rst_done", o_done, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    $display("[TB] add/adc carry chain");
    applyStimulus(1, LD, 8'hF0);
    checkOutput("ld_f0_acc",  o_acc,  8'hF0);
    checkOutput("ld_f0_done", o_done, 1);
    applyStimulus(1, ADD, 8'h20);
    checkOutput("add_acc",  o_acc,  8'h10);
    checkOutput("add_c",    o_c,    1);
    checkOutput("add_z",    o_z,    0);
    checkOutput("add_done", o_done, 1);
    applyStimulus(1, ADC, 8'h00);
    checkOutput("adc_acc",  o_acc,  8'h11);
    checkOutput("adc_c",    o_c,    0);
    checkOutput("adc_done", o_done, 1);
    applyStimulus(1, NOP, 8'h55);
    checkOutput("nop_acc",  o_acc,  8'h11);
    checkOutput("nop_done", o_done, 1);
    applyStimulus(0, LD, 8'h77);
    checkOutput("idle_acc",  o_acc,  8'h11);
    checkOutput("idle_done", o_done, 0);

    $display("[TB] subtract and borrow");
    applyStimulus(1, LD, 8'h05);
    applyStimulus(1, SUB, 8'h05);
    checkOutput("sub_zero_acc", o_acc, 8'h00);
    checkOutput("sub_zero_z",   o_z,   1);
    checkOutput("sub_zero_c",   o_c,   0);
    applyStimulus(1, SUB, 8'h01);
    checkOutput("sub_borrow_acc", o_acc, 8'hFF);
    checkOutput("sub_borrow_c",   o_c,   1);
    checkOutput("sub_borrow_z",   o_z,   0);

    $display("[TB] shifts and logic");
    applyStimulus(1, LD, 8'h81);
    checkOutput("ld_keeps_c", o_c, 1);
    applyStimulus(1, SHL, 8'h00);
    checkOutput("shl_acc", o_acc, 8'h02);
    checkOutput("shl_c",   o_c,   1);
    applyStimulus(1, SHR, 8'h00);
    checkOutput("shr_acc", o_acc, 8'h01);
    checkOutput("shr_c",   o_c,   0);
    applyStimulus(1, NOT, 8'h00);
    checkOutput("not_acc", o_acc, 8'hFE);
    applyStimulus(1, AND, 8'h0F);
    checkOutput("and_acc", o_acc, 8'h0E);
    applyStimulus(1, OR, 8'h30);
    checkOutput("or_acc", o_acc, 8'h3E);
    applyStimulus(1, XOR, 8'h3E);
    checkOutput("xor_acc", o_acc, 8'h00);
    checkOutput("xor_z",   o_z,   1);
    checkOutput("xor_c",   o_c,   0);
    applyStimulus(1, 4'd13, 8'hFF);
    checkOutput("op13_acc",  o_acc,  8'h00);
    checkOutput("op13_z",    o_z,    1);
    checkOutput("op13_done", o_done, 1);

`ifdef ALU_MUL_EN
    $display("[TB] multiply 0xFF x 0xFF with blocked issue");
    applyStimulus(1, LD, 8'hFF);
    applyStimulus(1, MUL, 8'hFF);
    checkOutput("mul_accept_busy", o_busy, 1);
    checkOutput("mul_accept_done", o_done, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, LD, 8'h55);
      if (i < 8) begin
        checkOutput($sformatf("mul_busy_%0d", i), o_busy, 1);
        checkOutput($sformatf("mul_hold_%0d", i), o_acc, 8'hFF);
      end
    end
    checkOutput("mul_end_busy", o_busy, 0);
    checkOutput("mul_end_done", o_done, 1);
    checkOutput("mul_end_acc",  o_acc,  8'h01);
    checkOutput("mul_end_hi",   o_hi,   8'hFE);
    checkOutput("mul_end_c",    o_c,    0);
    checkOutput("mul_end_z",    o_z,    0);
    applyStimulus(1, LD, 8'h77);
    checkOutput("post_mul_ld_acc", o_acc, 8'h77);
    checkOutput("post_mul_ld_hi",  o_hi,  8'hFE);
    applyStimulus(0, NOP, 8'h00);
    checkOutput("post_mul_idle_done", o_done, 0);

    $display("[TB] reset mid-multiply");
    applyStimulus(1, LD, 8'h12);
    applyStimulus(1, MUL, 8'h34);
    for (int i = 0; i < 4; i++) applyStimulus(0, NOP, 8'h00);
    #3;
    i_rst = 1'b1;
    #1;
    checkOutput("mulrst_acc",  o_acc,  8'h00);
    checkOutput("mulrst_hi",   o_hi,   8'h00);
    checkOutput("mulrst_busy", o_busy, 0);
    checkOutput("mulrst_done", o_done, 0);
    checkOutput("mulrst_z",    o_z,    1);
    @(negedge i_clk);
    i_rst = 1'b0;
    applyStimulus(0, NOP, 8'h00);
    checkOutput("mulrst_after_done", o_done, 0);
    checkOutput("mulrst_after_acc",  o_acc,  8'h00);

    applyStimulus(1, LD, 8'h03);
    applyStimulus(1, MUL, 8'h04);
    n = 0;
    while (!o_done && n < 20) begin
      applyStimulus(0, NOP, 8'h00);
      n++;
    end
    checkOutput("mul3x4_done_seen", o_done, 1);
    checkOutput("mul3x4_latency",   n,      8);
    checkOutput("mul3x4_acc",       o_acc,  8'h0C);
    checkOutput("mul3x4_hi",        o_hi,   8'h00);
    checkOutput("mul3x4_z",         o_z,    0);
`else
    $display("[TB] opcode 11 without multiplier");
    applyStimulus(1, LD, 8'h44);
    applyStimulus(1, MUL, 8'h02);
    checkOutput("op11_acc",  o_acc,  8'h44);
    checkOutput("op11_done", o_done, 1);
    checkOutput("op11_busy", o_busy, 0);
    checkOutput("op11_hi",   o_hi,   8'h00);
    applyStimulus(1, ADD, 8'h01);
    checkOutput("op11_next_acc", o_acc, 8'h45);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_acc.md
Name: alu_acc

Overview:
Accumulator-based ALU stage directly upstream of the register-file data path. It consumes the register-file read bus as operand B, combines it with the internal accumulator, and drives the accumulator onto the register-file write-data bus. Most operations are single-cycle. The optional multiply is a multi-cycle shift-add operation with a BUSY/DONE handshake toward the control unit.

Parameters:
WIDTH, 8, data path width; must match the register-file width.
OP_SIZE, 4, opcode width.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  execute strobe; sampled on the rising edge only while BUSY=0.
OP  input  OP_SIZE  opcode; sampled together with EN.
B  input  WIDTH  operand B, driven from the register-file OUT bus.
ACC  output  WIDTH  accumulator; drives the register-file IN bus.
HI  output  WIDTH  high half of the last MUL result.
C  output  1  carry/borrow flag.
Z  output  1  zero flag.
BUSY  output  1  multi-cycle operation in progress.
DONE  output  1  single-cycle pulse: the result from the last accepted op is valid.

Behaviour:
- Reset (asynchronous, any time including mid-MUL):
  - ACC=0, HI=0, C=0, Z=1, BUSY=0, DONE=0.
  - FSM goes to IDLE and any pending MUL is aborted with no partial result visible.
- FSM states:
  - IDLE → MUL on EN=1 with OP=MUL.
  - MUL → IDLE after WIDTH iterations.
  - All other accepted ops stay in IDLE.
- Opcodes:
  - 0 NOP: no change.
  - 1 LD: ACC=B; C unchanged.
  - 2 ADD: {C,ACC}=ACC+B.
  - 3 ADC: {C,ACC}=ACC+B+C.
  - 4 SUB: ACC=ACC-B; C=1 on borrow (ACC<B unsigned).
  - 5 AND, 6 OR, 7 XOR: bitwise with B; C unchanged.
  - 8 NOT: ACC=~ACC; C unchanged.
  - 9 SHL: C=ACC[MSB], ACC={ACC[WIDTH-2:0],0}.
  - 10 SHR: C=ACC[0], ACC={0,ACC[WIDTH-1:1]}.
  - 11 MUL: see below.
  - 12–15: treated as NOP.
- Flags and arithmetic:
  - Z is updated by every non-NOP op and reflects the new ACC (for MUL, reflects {HI,ACC}==0).
  - All arithmetic is unsigned and modulo 2^WIDTH; the carry-out goes only to C.
- Single-cycle timing:
  - Result is visible on ACC one cycle after the EN edge.
  - DONE=1 for exactly the cycle following the edge.
  - Back-to-back EN every cycle is legal, and DONE stays high while ops are accepted consecutively.
- MUL:
  - Latches multiplicand=ACC and multiplier=B at acceptance; BUSY=1 from the next cycle.
  - Runs WIDTH shift-add iterations, one per cycle, using an internal iteration counter.
  - On the edge ending the last iteration: {HI,ACC}=full 2*WIDTH product, C=0, BUSY=0, DONE=1 for one cycle.
  - Total latency is WIDTH+1 edges from acceptance to DONE.
  - ACC and HI hold their pre-MUL values while BUSY=1.
- EN/OP while BUSY=1 are ignored and not queued. EN asserted in the same cycle that BUSY falls is accepted normally.
- HI is written only by MUL.

Optional Feature:
ALU_MUL_EN
- Defined: the MUL opcode, the MUL state, the iteration counter and the HI register are present.
- Undefined:
  - Opcode 11 acts as NOP (DONE still pulses).
  - BUSY is tied to 0 and HI to 0.
  - The FSM reduces to IDLE only.

Decomposition:
- Shared package (cpu_pkg): opcode localparams (OP_NOP … OP_MUL), FSM state encoding, and a default WIDTH constant shared with the register file.
- One natural sub-module, alu_mul_seq: the shift-add multiplier datapath, counter and done strobe, instantiated only under ALU_MUL_EN.
- alu_acc keeps the opcode decode, flags and accumulator.

Test Plan:
1. RST pulsed asynchronously mid-cycle → ACC=0x00, HI=0x00, Z=1, C=0, BUSY=0 immediately, without waiting for a clock edge.
2. LD B=0xF0, then ADD B=0x20 → ACC=0x10, C=1, Z=0; then ADC B=0x00 → ACC=0x11, C=0; DONE high on every cycle after an accepted op.
3. LD 0x05, SUB B=0x05 → ACC=0x00, Z=1, C=0; SUB B=0x01 → ACC=0xFF, C=1, Z=0.
4. LD 0x81, SHL → ACC=0x02, C=1; SHR → ACC=0x01, C=0; NOT → ACC=0xFE.
5. ALU_MUL_EN: LD 0xFF, MUL B=0xFF → BUSY high for 8 cycles, EN+LD issued during BUSY ignored, then DONE pulse with HI=0xFE, ACC=0x01.
6. ALU_MUL_EN: MUL started, RST asserted at iteration 4 → all outputs at reset values, BUSY=0, no DONE; a subsequent MUL 0x03×0x04 gives ACC=0x0C, HI=0x00.
